// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared game-state encoding and score/pending limits
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [2:0]  PEND_MAX  = 3'd7;
  localparam logic [11:0] SCORE_MAX = 12'h999;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decimal digit counter, wraps 9->0 and flags carry
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc_in) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - game FSM with pending-point queue, BCD score and best score
module score_ctrl
  import score_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle,
  input  logic        start,
  input  logic        pass,
  input  logic        lose,
  output logic [11:0] score,
  output logic [11:0] best,
  output logic [1:0]  state,
  output logic        pend_ovf
);

  state_t     st;
  logic [2:0] pending;
  logic       game_start;
  logic       issue;
  logic       inc_ones;
  logic       inc_tens;
  logic       inc_hund;
  logic       carry_unused;

  assign state      = st;
  assign game_start = ((st == IDLE) || (st == OVER)) && start;
  assign issue      = (st == PLAY) && cycle && (pending != 3'd0) && !lose;
  // Saturation: an issue at 999 still drains pending but never reaches the digits.
  assign inc_ones   = issue && (score != SCORE_MAX);

  bcd_digit u_ones (
    .clk       (clk),
    .reset     (reset),
    .clr       (game_start),
    .inc_in    (inc_ones),
    .digit     (score[3:0]),
    .carry_out (inc_tens)
  );

  bcd_digit u_tens (
    .clk       (clk),
    .reset     (reset),
    .clr       (game_start),
    .inc_in    (inc_tens),
    .digit     (score[7:4]),
    .carry_out (inc_hund)
  );

  bcd_digit u_hund (
    .clk       (clk),
    .reset     (reset),
    .clr       (game_start),
    .inc_in    (inc_hund),
    .digit     (score[11:8]),
    .carry_out (carry_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      pending  <= 3'd0;
      pend_ovf <= 1'b0;
      best     <= 12'h000;
    end else begin
      case (st)
        IDLE, OVER: begin
          if (start) begin
            st       <= PLAY;
            pending  <= 3'd0;
            pend_ovf <= 1'b0;
          end
        end
        PLAY: begin
          if (lose) begin
            st      <= OVER;
            pending <= 3'd0;
            // BCD digits order the same as binary, so a plain compare suffices.
            if (score > best) best <= score;
          end else if (issue && !pass) begin
            pending <= pending - 3'd1;
          end else if (pass && !issue) begin
            if (pending == PEND_MAX) pend_ovf <= 1'b1;
            else                     pending  <= pending + 3'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - directed self-checking bench for score_ctrl
module tb_score_ctrl;

  logic        clk;
  logic        reset;
  logic        cycle;
  logic        start;
  logic        pass;
  logic        lose;
  logic [11:0] score;
  logic [11:0] best;
  logic [1:0]  state;
  logic        pend_ovf;

  int tests_run;
  int tests_failed;

  score_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cycle    (cycle),
    .start    (start),
    .pass     (pass),
    .lose     (lose),
    .score    (score),
    .best     (best),
    .state    (state),
    .pend_ovf (pend_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic c, input logic s, input logic l);
    pass  = p;
    cycle = c;
    start = s;
    lose  = l;
    @(posedge clk);
    #1;
    pass  = 1'b0;
    cycle = 1'b0;
    start = 1'b0;
    lose  = 1'b0;
  endtask

  task automatic award(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    cycle = 1'b0;
    start = 1'b0;
    pass  = 1'b0;
    lose  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {10'd0, state}, 12'd0);
    check("rst_score", score, 12'h000);
    check("rst_best", best, 12'h000);
    check("rst_ovf", {11'd0, pend_ovf}, 12'd0);
    reset = 1'b1;

    // Game 1: basic accrual, then lose with strobe coincident
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("g1_start_state", {10'd0, state}, 12'd1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("g1_pass_no_score", score, 12'h000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("g1_latency", score, 12'h001);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("g1_score3", score, 12'h003);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("g1_pending_empty", score, 12'h003);
    award(2);
    check("g1_score5", score, 12'h005);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("g1_lose_state", {10'd0, state}, 12'd2);
    check("g1_lose_score", score, 12'h005);
    check("g1_best", best, 12'h005);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("over_ignores_pass", score, 12'h005);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("over_ignores_lose", {10'd0, state}, 12'd2);

    // Game 2: restart from OVER, start ignored in PLAY, lower final score
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("g2_state", {10'd0, state}, 12'd1);
    check("g2_score_clr", score, 12'h000);
    check("g2_best_kept", best, 12'h005);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("g2_pending_clr", score, 12'h000);
    award(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("g2_start_in_play", score, 12'h001);
    check("g2_start_in_play_st", {10'd0, state}, 12'd1);
    award(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("g2_score3", score, 12'h003);
    check("g2_best_stays", best, 12'h005);

    // Game 3: issue and pass together at pending=7, then overflow
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("g3_ovf_at7", {11'd0, pend_ovf}, 12'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("g3_issue_pass_score", score, 12'h001);
    check("g3_issue_pass_ovf", {11'd0, pend_ovf}, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("g3_ovf_set", {11'd0, pend_ovf}, 12'd1);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("g3_drain", score, 12'h008);
    check("g3_ovf_sticky", {11'd0, pend_ovf}, 12'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("g3_best", best, 12'h008);
    check("g3_ovf_in_over", {11'd0, pend_ovf}, 12'd1);

    // Game 4: nine passes without strobe
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("g4_ovf_clr", {11'd0, pend_ovf}, 12'd0);
    repeat (9) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("g4_ovf", {11'd0, pend_ovf}, 12'd1);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("g4_score7", score, 12'h007);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("g4_best_kept", best, 12'h008);

    // Game 5: carry ripple and saturation
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    award(9);
    check("g5_009", score, 12'h009);
    award(1);
    check("g5_010", score, 12'h010);
    award(89);
    check("g5_099", score, 12'h099);
    award(1);
    check("g5_100", score, 12'h100);
    award(899);
    check("g5_999", score, 12'h999);
    award(1);
    check("g5_sat", score, 12'h999);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("g5_best", best, 12'h999);

    // Game 6: asynchronous reset mid-PLAY
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    award(3);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("g6_score3", score, 12'h003);
    #2;
    reset = 1'b0;
    #1;
    check("async_state", {10'd0, state}, 12'd0);
    check("async_score", score, 12'h000);
    check("async_best", best, 12'h000);
    check("async_ovf", {11'd0, pend_ovf}, 12'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_pass_state", {10'd0, state}, 12'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_state", {10'd0, state}, 12'd1);
    check("post_rst_no_pending", score, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
